// File: rtl/phase_seq_pkg.sv
// Shared constants and width helper for the phase sequencer.
package phase_seq_pkg;

  localparam int unsigned NPHASE_DEF = 4;
  localparam int unsigned CNTW_DEF   = 16;

  // Width of a binary phase index; never narrower than one bit.
  function automatic int unsigned calc_pw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/onehot_enc.sv
// One-hot to binary encoder; an all-zero input encodes to 0.
module onehot_enc #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] onehot_i,
  output logic [W-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (onehot_i[i]) begin
        bin_o = bin_o | W'(i);
      end
    end
  end

endmodule

// File: rtl/phase_seq.sv
// One-hot CPU phase sequencer with stall, stop, single-step, abort and a
// retired-instruction counter.
module phase_seq
  import phase_seq_pkg::*;
#(
  parameter  int unsigned NPHASE = NPHASE_DEF,
  parameter  int unsigned CNTW   = CNTW_DEF,
  localparam int unsigned PW     = calc_pw(NPHASE)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              stop,
  input  logic              stall,
  input  logic              step_mode,
  input  logic              abort,
  output logic [NPHASE-1:0] q,
  output logic [PW-1:0]     phase_idx,
  output logic              busy,
  output logic              retire,
  output logic              stop_pend,
  output logic [CNTW-1:0]   instr_cnt
);

  logic [NPHASE-1:0] q_q, q_d;
  logic              stop_pend_q, stop_pend_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  logic              q_legal;
  logic              idle;
  logic              last;
  logic [NPHASE-1:0] enc_in;

  // At most one bit set; anything else is treated as corrupted state.
  assign q_legal = (q_q & (q_q - NPHASE'(1))) == '0;
  assign idle    = (q_q == '0);
  assign last    = q_q[NPHASE-1] & q_legal;

  assign retire    = last & ~stall & ~abort & ~RST;
  assign busy      = ~idle & ~RST;
  assign q         = q_q;
  assign stop_pend = stop_pend_q;
  assign instr_cnt = cnt_q;
  assign enc_in    = RST ? '0 : q_q;

  onehot_enc #(
    .N (NPHASE),
    .W (PW)
  ) u_enc (
    .onehot_i (enc_in),
    .bin_o    (phase_idx)
  );

  always_comb begin
    q_d         = q_q;
    stop_pend_d = stop_pend_q;
    cnt_d       = cnt_q;
    if (!q_legal) begin
      q_d         = '0;
      stop_pend_d = 1'b0;
    end else if (idle) begin
      // abort in idle also swallows a coincident start
      if (start && !abort) begin
        q_d = NPHASE'(1);
      end
    end else if (abort) begin
      q_d         = '0;
      stop_pend_d = 1'b0;
    end else begin
      if (stop) begin
        stop_pend_d = 1'b1;
      end
      if (!stall) begin
        if (last) begin
          cnt_d = cnt_q + CNTW'(1);
          if (stop || stop_pend_q || step_mode) begin
            q_d         = '0;
            stop_pend_d = 1'b0;
          end else begin
            q_d = NPHASE'(1);
          end
        end else begin
          q_d = q_q << 1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q         <= '0;
      stop_pend_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      q_q         <= q_d;
      stop_pend_q <= stop_pend_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: doc/phase_seq.md
PHASE_SEQ -- requirements
Module: phase_seq

Interface
REQ-001 Parameter NPHASE, default 4, number of one-hot CPU phases; legal range 2..16.
REQ-002 Parameter CNTW, default 16, width of the retired-instruction counter; legal range 1..32.
REQ-003 Local constant PW = max(1, ceil(log2(NPHASE))), width of phase_idx.
REQ-004 One clock; reset is synchronous and active-high: CLK input 1, sole clock, rising edge.
REQ-005 RST input 1: synchronous, active-high reset.
REQ-006 start input 1: begin running from idle.
REQ-007 stop input 1: request halt at the end of the current instruction.
REQ-008 stall input 1: hold the current phase.
REQ-009 step_mode input 1: single-step, return to idle after every instruction.
REQ-010 abort input 1: immediate return to idle.
REQ-011 q output NPHASE: one-hot phase vector; all-zero means idle.
REQ-012 phase_idx output PW: binary index of the active phase; 0 when idle.
REQ-013 busy output 1: high when q is non-zero.
REQ-014 retire output 1: single-cycle strobe marking the completion of an instruction.
REQ-015 stop_pend output 1: latched stop request.
REQ-016 instr_cnt output CNTW: count of retired instructions.

Function
REQ-017 Registered state shall be q, stop_pend and instr_cnt; busy, phase_idx and retire shall be combinational decodes of the state and inputs.
REQ-018 Priority, highest first, shall be: RST, abort, stall, normal sequencing.
REQ-019 Idle (q=0): start=1 -> q=1 (phase 0) at the next edge; start=0 -> remain idle; stop, stall and step_mode shall be ignored while idle.
REQ-020 Phase k with k<NPHASE-1 and stall=0 shall advance to phase k+1 in one cycle; stall=1 shall hold phase k.
REQ-021 Last phase (NPHASE-1) with stall=0 shall go to idle when any of stop, stop_pend or step_mode is 1, and to phase 0 otherwise.
REQ-022 retire = q[NPHASE-1] & ~stall & ~abort; instr_cnt shall increment by 1 at the same edge, wrapping from 2^CNTW-1 to 0.
REQ-023 stop_pend shall set when stop=1 while busy and clear at the edge entering idle; stop asserted while stalled shall still be latched.
REQ-024 abort=1 while busy shall force q=0 and stop_pend=0 at the next edge, with no retire and no count; abort in idle shall have no effect, and start is ignored in that cycle.
REQ-025 start while busy shall be ignored.
REQ-026 q shall never hold more than one bit set; any illegal value shall recover to idle at the next edge.
REQ-027 Minimum instruction latency shall be NPHASE cycles; each stall cycle shall add one cycle.

Reset
REQ-028 RST=1 at a rising edge shall force q=0, stop_pend=0 and instr_cnt=0, overriding all other inputs, including mid-instruction.
REQ-029 During reset, busy=0, retire=0 and phase_idx=0.

Structure
REQ-030 A shared package phase_seq_pkg shall hold NPHASE_DEF=4, CNTW_DEF=16 and the PW derivation function.
REQ-031 One sub-module, onehot_enc (NPHASE-bit one-hot to PW-bit binary, 0 for all-zero), shall produce phase_idx.

Verification
REQ-032 NPHASE=4, start pulse, stop held 0: q shall step 0001->0010->0100->1000->0001; retire shall be high each 4th cycle; instr_cnt=3 after 12 cycles.
REQ-033 stop pulsed in phase 1, start then 0: stop_pend=1 until the last phase, after which q=0 and instr_cnt increments by 1.
REQ-034 stall held 3 cycles in phase 2: q=0100 shall be held for 4 cycles with no retire, and the instruction shall take 7 cycles.
REQ-035 step_mode=1 with start pulsed twice: each start shall give exactly one 4-phase pass back to idle, and instr_cnt=2.
REQ-036 abort in phase 2 with stop_pend=1: q=0 and stop_pend=0 at the next edge, with instr_cnt unchanged; RST in phase 3 shall clear all state, with no retire.
REQ-037 CNTW=2, NPHASE=2, 5 continuous instructions: instr_cnt sequence 1,2,3,0,1, and phase_idx shall toggle 0/1.
